// File: rtl/hazard_scoreboard.sv
// Decode-stage register hazard scoreboard: per-register countdown of in-flight
// writes, interlock in full or load-use-only mode, and one-deep flush undo.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 3,
    parameter int PIPE_DEPTH = 3,
    parameter int FWD_EN     = 0,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_W-1:0]     id_rs,
    input  logic [REG_ADDR_W-1:0]     id_rt,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    input  logic                      id_wr,
    input  logic [REG_ADDR_W-1:0]     id_rd,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [(2**REG_ADDR_W)-1:0] busy,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam int CW       = $clog2(PIPE_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(PIPE_DEPTH);

    logic [CW-1:0]         cnt      [NUM_REGS];
    logic [CW-1:0]         cnt_nxt  [NUM_REGS];
    logic [NUM_REGS-1:0]   ld, ld_nxt;
    logic                  last_vld, last_vld_nxt;
    logic [REG_ADDR_W-1:0] last_rd, last_rd_nxt;
    logic [CW-1:0]         prev_cnt, prev_cnt_nxt;
    logic                  prev_ld, prev_ld_nxt;
    logic [CW-1:0]         restore_cnt;
    logic                  hazard_rs, hazard_rt, issue;

    always_comb begin
        hazard_rs = 1'b0;
        hazard_rt = 1'b0;
        if (FWD_EN != 0) begin
            hazard_rs = id_rs_used && (cnt[id_rs] == DEPTH) && ld[id_rs];
            hazard_rt = id_rt_used && (cnt[id_rt] == DEPTH) && ld[id_rt];
        end else begin
            hazard_rs = id_rs_used && (cnt[id_rs] != '0);
            hazard_rt = id_rt_used && (cnt[id_rt] != '0);
        end
    end

    // stall: combinational request to hold decode this cycle; flush overrides it
    // because the decode instruction is being discarded anyway.
    assign stall = id_valid && !flush && (hazard_rs || hazard_rt);
    assign issue = id_valid && !stall && !flush;

    // Squashed producer: the entry it replaced has aged two edges since the snapshot.
    assign restore_cnt = (prev_cnt > CW'(2)) ? prev_cnt - CW'(2) : '0;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CW'(1) : '0;
            ld_nxt[r]  = ld[r] && (cnt[r] > CW'(1));
        end
        last_vld_nxt = 1'b0;
        last_rd_nxt  = last_rd;
        prev_cnt_nxt = prev_cnt;
        prev_ld_nxt  = prev_ld;

        if (issue && id_wr) begin
            prev_cnt_nxt   = cnt[id_rd];
            prev_ld_nxt    = ld[id_rd];
            cnt_nxt[id_rd] = DEPTH;
            ld_nxt[id_rd]  = id_is_load;
            last_vld_nxt   = 1'b1;
            last_rd_nxt    = id_rd;
        end

        if (flush && last_vld) begin
            cnt_nxt[last_rd] = restore_cnt;
            ld_nxt[last_rd]  = prev_ld && (restore_cnt != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            ld        <= '0;
            last_vld  <= 1'b0;
            last_rd   <= '0;
            prev_cnt  <= '0;
            prev_ld   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            ld       <= ld_nxt;
            last_vld <= last_vld_nxt;
            last_rd  <= last_rd_nxt;
            prev_cnt <= prev_cnt_nxt;
            prev_ld  <= prev_ld_nxt;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (full interlock, load-use with
// forwarding, 4-bit counter) share stimulus and are checked against ready-time model.
module tb_hazard_scoreboard;

    localparam int PD = 3;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, flush;
    logic [2:0] id_rs, id_rt, id_rd;
    logic       stall0, stall1, stall2;
    logic [7:0] busy0, busy1, busy2;
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.REG_ADDR_W(3), .PIPE_DEPTH(PD), .FWD_EN(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(stall0), .busy(busy0), .stall_cnt(sc0)
    );
    hazard_scoreboard #(.REG_ADDR_W(3), .PIPE_DEPTH(PD), .FWD_EN(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(stall1), .busy(busy1), .stall_cnt(sc1)
    );
    hazard_scoreboard #(.REG_ADDR_W(3), .PIPE_DEPTH(PD), .FWD_EN(0), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_rd(id_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(stall2), .busy(busy2), .stall_cnt(sc2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each register holds the absolute cycle at which its value becomes
    // readable; busy while the current cycle is earlier than that.
    int ready    [3][8];
    bit mld      [3][8];
    bit lv       [3];
    int lrd      [3];
    int sv_ready [3];
    bit sv_ld    [3];
    int scnt     [3];
    int cyc = 0;

    function automatic int cnt_max(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic bit src_haz(input int k, input int r);
        if (k == 1) return ((ready[k][r] - cyc) == PD) && mld[k][r];
        return ready[k][r] > cyc;
    endfunction

    function automatic bit m_stall(input int k);
        bit h = 1'b0;
        if (!id_valid || flush) return 1'b0;
        if (id_rs_used && src_haz(k, int'(id_rs))) h = 1'b1;
        if (id_rt_used && src_haz(k, int'(id_rt))) h = 1'b1;
        return h;
    endfunction

    function automatic logic [7:0] m_busy(input int k);
        logic [7:0] b = '0;
        for (int r = 0; r < 8; r++) b[r] = ready[k][r] > cyc;
        return b;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++) begin
                ready[k][r] = 0;
                mld[k][r]   = 1'b0;
            end
            lv[k] = 1'b0; lrd[k] = 0; sv_ready[k] = 0; sv_ld[k] = 1'b0; scnt[k] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                bit st;
                bit iss;
                st  = m_stall(k);
                iss = id_valid && !st && !flush;
                if (st && scnt[k] < cnt_max(k)) scnt[k]++;
                if (flush && lv[k]) begin
                    ready[k][lrd[k]] = sv_ready[k];
                    mld[k][lrd[k]]   = sv_ld[k];
                end
                lv[k] = 1'b0;
                if (iss && id_wr) begin
                    sv_ready[k] = ready[k][id_rd];
                    sv_ld[k]    = mld[k][id_rd];
                    ready[k][id_rd] = cyc + 1 + PD;
                    mld[k][id_rd]   = id_is_load;
                    lv[k]  = 1'b1;
                    lrd[k] = int'(id_rd);
                end
            end
        end
        cyc++;
    end

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input logic s, input logic [7:0] b, input logic [31:0] sc);
        chk($sformatf("stall_u%0d", k), 32'(s), 32'(m_stall(k)));
        chk($sformatf("busy_u%0d", k), 32'(b), 32'(m_busy(k)));
        chk($sformatf("stall_cnt_u%0d", k), sc, 32'(scnt[k]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, stall0, busy0, 32'(sc0));
        cmp_inst(1, stall1, busy1, 32'(sc1));
        cmp_inst(2, stall2, busy2, 32'(sc2));
    end

    // driver tasks
    task automatic set_in(input logic v, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu, input logic wr,
                          input logic [2:0] rd, input logic ld, input logic fl);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_wr = wr; id_rd = rd; id_is_load = ld; flush = fl;
    endtask

    task automatic idle();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        idle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_reset();
        #3;
        chk("reset_stall", 32'(stall0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_cnt", 32'(sc0), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // full interlock: write r3, consumer rs=r3 held until it issues
        do_reset();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("s1_stall_c%0d", i), 32'(stall0), (i < 4) ? 32'd1 : 32'd0);
            if (i == 1) chk("s1_busy", 32'(busy0), 32'h08);
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("s1_cnt_dut", 32'(sc0), 32'd3);
        chk("s1_cnt_model", 32'(scnt[0]), 32'd3);
        chk("s1_fwd_cnt", 32'(sc1), 32'd0);
        next_cycle();

        // load-use with forwarding: exactly one stall
        do_reset();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("s2_ld_stall_c%0d", i), 32'(stall1), (i == 1) ? 32'd1 : 32'd0);
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("s2_ld_cnt_dut", 32'(sc1), 32'd1);
        chk("s2_ld_cnt_model", 32'(scnt[1]), 32'd1);
        next_cycle();

        // ALU producer with forwarding: no stall
        do_reset();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("s2_alu_stall", 32'(stall1), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("s2_alu_cnt", 32'(sc1), 32'd0);
        next_cycle();

        // unused source field must not stall
        do_reset();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("s3_unused", 32'(stall0), 32'd0);
        next_cycle();
        set_in(1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("s3_used", 32'(stall0), 32'd1);
        next_cycle();

        // WAW on r5 then flush of the younger writer
        do_reset();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("s4_busy5_c3", 32'(busy0[5]), 32'd1);
        chk("s4_model_c3", 32'(m_busy(0)), 32'h20);
        next_cycle();
        @(negedge clk);
        chk("s4_busy5_c4", 32'(busy0[5]), 32'd0);
        next_cycle();

        // async reset in mid-cycle while r1/r6 busy and stalling
        do_reset();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
        next_cycle();
        set_in(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("s5_pre_stall", 32'(stall0), 32'd1);
        chk("s5_pre_busy", 32'(busy0), 32'h42);
        chk("s5_pre_cnt", 32'(sc0), 32'd1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("s5_rst_stall", 32'(stall0), 32'd0);
        chk("s5_rst_busy", 32'(busy0), 32'd0);
        chk("s5_rst_cnt", 32'(sc0), 32'd0);
        idle();
        next_cycle();
        rst_n = 1'b1;

        // saturation: 7 groups of load-then-consumer on r7
        do_reset();
        for (int g = 0; g < 7; g++) begin
            set_in(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
            next_cycle();
            for (int i = 0; i < 4; i++) begin
                set_in(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
                next_cycle();
            end
        end
        idle();
        @(negedge clk);
        chk("s6_sat_dut", 32'(sc2), 32'd15);
        chk("s6_sat_model", 32'(scnt[2]), 32'd15);
        chk("s6_wide_cnt", 32'(sc0), 32'd21);
        chk("s6_fwd_cnt", 32'(sc1), 32'd7);
        next_cycle();

        // randomized traffic with flushes and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                m_reset();
            end
            set_in($urandom_range(9) < 8, 3'($urandom_range(7)), $urandom_range(9) < 7,
                   3'($urandom_range(7)), $urandom_range(9) < 7, $urandom_range(9) < 6,
                   3'($urandom_range(7)), $urandom_range(9) < 3, $urandom_range(99) < 8);
            next_cycle();
        end
        rst_n = 1'b1;
        idle();
        next_cycle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
